int_sequencer: RTL and testbench

Multi-cycle interrupt sequencer for the pipelined processor. It detects an external interrupt request, waits for the memory stage to drain, then drives the control unit's `INT` input. While `INT` is high it sequences the pushes of the return PC and flags onto the stack, then fetches the interrupt vector from memory and loads it into the PC. It sits between the interrupt pin, the fetch/PC logic and the decode-stage control unit, and it stalls fetch for the whole sequence.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/int_sequencer_if.sv | 39 +++
 rtl/int_sequencer_edge_det.sv | 49 ++++
 rtl/int_sequencer.sv | 156 +++++++++++++++
 tb/tb_int_sequencer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared processor types: interrupt sequencer state encoding and default datapath widths.
package cpu_pkg;

  localparam int PC_W_DEF   = 32;
  localparam int WORD_W_DEF = 16;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    PUSH_PC,
    PUSH_FLG,
    VEC_RD,
    VEC_LD,
    DONE
  } int_state_t;

endpackage

// File: rtl/int_sequencer_if.sv
// Interrupt sequencer bus: interrupt pin, pipeline status, stack/vector memory
// strobes and PC load. master = sequencer, slave = processor side.
interface int_sequencer_if import cpu_pkg::*; #(
  parameter int PC_W   = PC_W_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              int_req;
  logic              mem_busy;
  logic              branch_flush;
  logic [PC_W-1:0]   pc_cur;
  logic [WORD_W-1:0] mem_rdata;

  logic              int_active;
  logic              stall_fetch;
  logic              flush;
  logic              mem_wr;
  logic              mem_rd;
  logic              push_flags;
  logic [WORD_W-1:0] push_word;
  logic [ADDR_W-1:0] mem_addr;
  logic              pc_load;
  logic [PC_W-1:0]   pc_new;
  logic              int_ack;

  modport master (
    input  int_req, mem_busy, branch_flush, pc_cur, mem_rdata,
    output int_active, stall_fetch, flush, mem_wr, mem_rd, push_flags,
           push_word, mem_addr, pc_load, pc_new, int_ack
  );

  modport slave (
    output int_req, mem_busy, branch_flush, pc_cur, mem_rdata,
    input  int_active, stall_fetch, flush, mem_wr, mem_rd, push_flags,
           push_word, mem_addr, pc_load, pc_new, int_ack
  );

endinterface

// File: rtl/int_sequencer_edge_det.sv
// Interrupt request edge detector holding one pending request.
// INT_SYNC_EN adds a 2-flop synchroniser in front of the edge detector.
module int_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic int_req,
  input  logic clr,
  output logic pending
);

  logic req_s;
  logic req_q;
  logic rise;

`ifdef INT_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], int_req};
    end
  end

  assign req_s = sync_q[1];
`else
  assign req_s = int_req;
`endif

  assign rise = req_s & ~req_q;

  // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= 1'b0;
      pending <= 1'b0;
    end else begin
      req_q <= req_s;
      // A new edge wins over the clear, so it is not lost on sequence entry.
      if (rise) begin
        pending <= 1'b1;
      end else if (clr) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/int_sequencer.sv
// Multi-cycle interrupt sequencer: waits for the memory stage, pushes PC and flags,
// fetches the vector and loads it into the PC. INT_SYNC_EN enables the input synchroniser.
module int_sequencer import cpu_pkg::*; #(
  parameter int          PC_W     = PC_W_DEF,
  parameter int          WORD_W   = WORD_W_DEF,
  parameter int unsigned VEC_ADDR = 0,
  parameter int          ADDR_W   = ADDR_W_DEF
) (
  input logic             clk,
  input logic             rst,
  int_sequencer_if.master bus
);

  localparam int                NW       = PC_W / WORD_W;
  localparam int                IDX_W    = $clog2(NW) + 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NW - 1);

  int_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [PC_W-1:0]  pc_lat;
  logic [PC_W-1:0]  vec_acc;
  logic [PC_W-1:0]  vec_full;
  logic             pending;
  logic             enter_push;

  function automatic logic [WORD_W-1:0] pc_word(input logic [PC_W-1:0] pc, input int w);
    return WORD_W'(pc >> (w * WORD_W));
  endfunction

  assign enter_push = (state == WAIT) && !bus.mem_busy && !bus.branch_flush;

  int_edge_det u_edge (
    .clk     (clk),
    .rst     (rst),
    .int_req (bus.int_req),
    .clr     (enter_push),
    .pending (pending)
  );

  // The last vector word arrives during VEC_LD, so the loaded PC merges it in directly.
  assign vec_full   = (vec_acc << WORD_W) | PC_W'(bus.mem_rdata);
  assign bus.pc_new = bus.pc_load ? vec_full : vec_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      pc_lat          <= '0;
      vec_acc         <= '0;
      bus.int_active  <= 1'b0;
      bus.stall_fetch <= 1'b0;
      bus.flush       <= 1'b0;
      bus.mem_wr      <= 1'b0;
      bus.mem_rd      <= 1'b0;
      bus.push_flags  <= 1'b0;
      bus.push_word   <= '0;
      bus.mem_addr    <= '0;
      bus.pc_load     <= 1'b0;
      bus.int_ack     <= 1'b0;
    end else begin
      // Outputs are registered for the state being entered; anything not set drops to 0.
      bus.int_active  <= 1'b0;
      bus.stall_fetch <= 1'b0;
      bus.flush       <= 1'b0;
      bus.mem_wr      <= 1'b0;
      bus.mem_rd      <= 1'b0;
      bus.push_flags  <= 1'b0;
      bus.push_word   <= '0;
      bus.mem_addr    <= '0;
      bus.pc_load     <= 1'b0;
      bus.int_ack     <= 1'b0;

      case (state)
        IDLE: begin
          if (pending) begin
            state           <= WAIT;
            idx             <= '0;
            bus.stall_fetch <= 1'b1;
          end
        end

        WAIT: begin
          bus.stall_fetch <= 1'b1;
          if (enter_push) begin
            state          <= PUSH_PC;
            idx            <= '0;
            pc_lat         <= bus.pc_cur;
            bus.int_active <= 1'b1;
            bus.mem_wr     <= 1'b1;
            bus.flush      <= 1'b1;
            bus.push_word  <= pc_word(bus.pc_cur, NW - 1);
          end
        end

        PUSH_PC: begin
          bus.stall_fetch <= 1'b1;
          bus.int_active  <= 1'b1;
          bus.mem_wr      <= 1'b1;
          if (idx == IDX_LAST) begin
            state          <= PUSH_FLG;
            idx            <= '0;
            bus.push_flags <= 1'b1;
          end else begin
            idx           <= idx + IDX_W'(1);
            bus.push_word <= pc_word(pc_lat, NW - 2 - int'(idx));
          end
        end

        PUSH_FLG: begin
          state           <= VEC_RD;
          idx             <= '0;
          bus.stall_fetch <= 1'b1;
          bus.int_active  <= 1'b1;
          bus.mem_rd      <= 1'b1;
          bus.mem_addr    <= ADDR_W'(VEC_ADDR);
        end

        VEC_RD: begin
          bus.stall_fetch <= 1'b1;
          // Read data lags the strobe by one cycle, so nothing is valid in the first cycle.
          if (idx != '0) begin
            vec_acc <= vec_full;
          end
          if (idx == IDX_LAST) begin
            state       <= VEC_LD;
            idx         <= '0;
            bus.pc_load <= 1'b1;
          end else begin
            idx            <= idx + IDX_W'(1);
            bus.int_active <= 1'b1;
            bus.mem_rd     <= 1'b1;
            bus.mem_addr   <= ADDR_W'(VEC_ADDR) + ADDR_W'(idx) + ADDR_W'(1);
          end
        end

        VEC_LD: begin
          state       <= DONE;
          idx         <= '0;
          vec_acc     <= vec_full;
          bus.int_ack <= 1'b1;
        end

        DONE: begin
          state <= IDLE;
          idx   <= '0;
        end

        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: per-cycle expected outputs come from a
// schedule model derived from the sequence timing rules.
module tb_int_sequencer;
  import cpu_pkg::*;

  localparam int PC_W   = 32;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 32;
  localparam int NW     = PC_W / WORD_W;
  localparam int VEC    = 0;
  localparam int MAXC   = 1024;

`ifdef INT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  typedef struct packed {
    logic        stall, act, flush, wr, rd, flg, ld, ack;
    logic        chk_pw, chk_addr, chk_pcn;
    logic [15:0] pw;
    logic [31:0] addr;
    logic [31:0] pcn;
  } exp_t;

  typedef struct {
    int base;
    int w;
  } seq_t;

  logic clk = 1'b0;
  logic rst;

  int_sequencer_if #(.PC_W(PC_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

  int_sequencer #(
    .PC_W     (PC_W),
    .WORD_W   (WORD_W),
    .VEC_ADDR (VEC),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  bit          req_plan   [MAXC];
  bit          busy_plan  [MAXC];
  bit          flush_plan [MAXC];
  logic [31:0] pc_plan    [MAXC];
  logic [15:0] vec_mem    [4];
  seq_t        seqs       [16];
  int          nseq;
  int          cyc;
  int          n_err;
  int          n_checks;
  bit          rd_prev;
  int          rd_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [31:0] pc, input int i);
    return 16'(pc >> (16 * i));
  endfunction

  function automatic logic [31:0] vector_value();
    logic [31:0] acc = '0;
    for (int k = 0; k < NW; k++) acc = (acc << 16) | 32'(vec_mem[VEC + k]);
    return acc;
  endfunction

  // Expected outputs in cycle c from the schedule of every registered sequence.
  function automatic exp_t model(input int c);
    exp_t e;
    e = '0;
    for (int s = 0; s < nseq; s++) begin
      int b  = seqs[s].base;
      int ps = b + 3 + seqs[s].w;
      if (c >= b + 2 && c < ps) begin
        e.stall = 1'b1;
      end else if (c >= ps && c < ps + NW) begin
        e.stall = 1'b1; e.act = 1'b1; e.wr = 1'b1;
        e.flush  = (c == ps);
        e.chk_pw = 1'b1;
        e.pw     = word_of(pc_plan[ps - 1], NW - 1 - (c - ps));
      end else if (c == ps + NW) begin
        e.stall = 1'b1; e.act = 1'b1; e.wr = 1'b1; e.flg = 1'b1;
      end else if (c > ps + NW && c <= ps + 2 * NW) begin
        e.stall = 1'b1; e.act = 1'b1; e.rd = 1'b1;
        e.chk_addr = 1'b1;
        e.addr     = 32'(VEC + (c - ps - NW - 1));
      end else if (c == ps + 2 * NW + 1) begin
        e.stall = 1'b1; e.ld = 1'b1;
        e.chk_pcn = 1'b1;
        e.pcn     = vector_value();
      end else if (c == ps + 2 * NW + 2) begin
        e.ack = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic compare(input exp_t e);
    check("stall_fetch", 64'(bus.stall_fetch), 64'(e.stall));
    check("int_active",  64'(bus.int_active),  64'(e.act));
    check("flush",       64'(bus.flush),       64'(e.flush));
    check("mem_wr",      64'(bus.mem_wr),      64'(e.wr));
    check("mem_rd",      64'(bus.mem_rd),      64'(e.rd));
    check("push_flags",  64'(bus.push_flags),  64'(e.flg));
    check("pc_load",     64'(bus.pc_load),     64'(e.ld));
    check("int_ack",     64'(bus.int_ack),     64'(e.ack));
    if (e.chk_pw)   check("push_word", 64'(bus.push_word), 64'(e.pw));
    if (e.chk_addr) check("mem_addr",  64'(bus.mem_addr),  64'(e.addr));
    if (e.chk_pcn)  check("pc_new",    64'(bus.pc_new),    64'(e.pcn));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".stall_fetch"}, 64'(bus.stall_fetch), 64'(0));
    check({tag, ".int_active"},  64'(bus.int_active),  64'(0));
    check({tag, ".flush"},       64'(bus.flush),       64'(0));
    check({tag, ".mem_wr"},      64'(bus.mem_wr),      64'(0));
    check({tag, ".mem_rd"},      64'(bus.mem_rd),      64'(0));
    check({tag, ".push_flags"},  64'(bus.push_flags),  64'(0));
    check({tag, ".push_word"},   64'(bus.push_word),   64'(0));
    check({tag, ".mem_addr"},    64'(bus.mem_addr),    64'(0));
    check({tag, ".pc_load"},     64'(bus.pc_load),     64'(0));
    check({tag, ".pc_new"},      64'(bus.pc_new),      64'(0));
    check({tag, ".int_ack"},     64'(bus.int_ack),     64'(0));
    check({tag, ".state"},       64'(dut.state),       64'(IDLE));
    check({tag, ".pending"},     64'(dut.u_edge.pending), 64'(0));
  endtask

  task automatic drive(input int c);
    bus.int_req      = req_plan[c];
    bus.mem_busy     = busy_plan[c];
    bus.branch_flush = flush_plan[c];
    bus.pc_cur       = pc_plan[c];
    if (rd_prev && rd_addr >= VEC && rd_addr < VEC + 4) bus.mem_rdata = vec_mem[rd_addr - VEC];
    else bus.mem_rdata = 16'($urandom);
  endtask

  task automatic one_cycle();
    @(posedge clk);
    #1;
    cyc++;
    drive(cyc);
    @(negedge clk);
    compare(model(cyc));
    rd_prev = bus.mem_rd;
    rd_addr = int'(bus.mem_addr);
  endtask

  task automatic run_until(input int last);
    while (cyc < last) one_cycle();
  endtask

  // Registers a sequence whose request is detected at cycle b; holds the pipe busy for w WAIT cycles.
  task automatic add_seq(input int b, input int w, input bit busy_only, output int done);
    seqs[nseq].base = b;
    seqs[nseq].w    = w;
    nseq++;
    for (int c = b + 2; c < b + 2 + w; c++) begin
      if (busy_only || $urandom_range(0, 1) == 1) begin
        busy_plan[c]  = 1'b1;
        flush_plan[c] = busy_only ? 1'b0 : 1'($urandom_range(0, 1));
      end else begin
        busy_plan[c]  = 1'b0;
        flush_plan[c] = 1'b1;
      end
    end
    busy_plan[b + 2 + w]  = 1'b0;
    flush_plan[b + 2 + w] = 1'b0;
    done = b + w + 2 * NW + 5;
  endtask

  task automatic new_vectors();
    for (int k = 0; k < 4; k++) vec_mem[k] = 16'($urandom);
  endtask

  initial begin
    int n, w, w2, ps, done1, done2;
    n_err = 0; n_checks = 0; nseq = 0; cyc = -1; rd_prev = 1'b0; rd_addr = 0;
    for (int c = 0; c < MAXC; c++) begin
      req_plan[c]   = 1'b0;
      busy_plan[c]  = 1'($urandom_range(0, 1));
      flush_plan[c] = 1'($urandom_range(0, 1));
      pc_plan[c]    = $urandom;
    end
    rst = 1'b1;
    bus.int_req = 1'b0; bus.mem_busy = 1'b0; bus.branch_flush = 1'b0;
    bus.pc_cur = '0; bus.mem_rdata = '0;
    #12;
    check_all_zero("reset");
    check("reset.idx", 64'(dut.idx), 64'(0));
    check("reset.pc_lat", 64'(dut.pc_lat), 64'(0));
    rst = 1'b0;

    // Idle pipe, request at cycle 10, fixed return PC and vector.
    for (int c = 0; c <= 35; c++) begin
      busy_plan[c] = 1'b0; flush_plan[c] = 1'b0; pc_plan[c] = 32'h0001_2345;
    end
    for (int c = 10; c <= 30; c++) req_plan[c] = 1'b1;
    vec_mem[0] = 16'h00AB; vec_mem[1] = 16'hCDEF;
    add_seq(10 + SYNC_LAT, 0, 1'b0, done1);
    run_until(35);

    // Memory stage busy for 4 cycles after the request becomes pending.
    new_vectors();
    for (int c = 40; c <= 45; c++) req_plan[c] = 1'b1;
    add_seq(40 + SYNC_LAT, 4, 1'b1, done1);
    run_until(done1 + 3);

    // Two edges during one sequence (one in VEC_RD) collapse into one follow-up sequence.
    new_vectors();
    n = cyc + 4;
    w = $urandom_range(0, 3);
    req_plan[n] = 1'b1; req_plan[n + 1] = 1'b1;
    add_seq(n + SYNC_LAT, w, 1'b0, done1);
    ps = n + SYNC_LAT + 3 + w;
    req_plan[ps + 1] = 1'b1;
    req_plan[ps + 4] = 1'b1;
    w2 = $urandom_range(0, 3);
    add_seq(done1, w2, 1'b0, done2);
    run_until(done2 + 3);

    // Edge in the same cycle the sequence enters PUSH_PC must stay pending.
    new_vectors();
    n = cyc + 4;
    w = $urandom_range(0, 3);
    req_plan[n] = 1'b1;
    add_seq(n + SYNC_LAT, w, 1'b0, done1);
    ps = n + SYNC_LAT + 3 + w;
    req_plan[ps - 1 - SYNC_LAT] = 1'b1;
    w2 = $urandom_range(0, 3);
    add_seq(done1, w2, 1'b0, done2);
    run_until(done2 + 3);

    // Reset asserted during PUSH_FLG aborts the sequence at once.
    nseq = 0;
    new_vectors();
    n = cyc + 4;
    for (int c = n; c <= n + 6; c++) req_plan[c] = 1'b1;
    add_seq(n + SYNC_LAT, 0, 1'b0, done1);
    run_until(n + SYNC_LAT + 4);
    @(posedge clk);
    #1;
    cyc++;
    drive(cyc);
    compare(model(cyc));
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    bus.int_req = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_all_zero("held_reset");
    @(negedge clk);
    rst = 1'b0;
    nseq = 0;
    rd_prev = 1'b0;
    for (int c = cyc + 1; c < cyc + 12; c++) req_plan[c] = 1'b0;
    run_until(cyc + 10);

    // Randomised back-to-back requests after recovery.
    for (int i = 0; i < 3; i++) begin
      new_vectors();
      n = cyc + 3 + $urandom_range(0, 4);
      w = $urandom_range(0, 5);
      req_plan[n] = 1'b1; req_plan[n + 1] = 1'b1;
      add_seq(n + SYNC_LAT, w, 1'b0, done1);
      run_until(done1 + 2);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
